alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
// - Registered stage directly downstream of the 4-bit ALU. It takes the ALU's parallel outputs
//   (add/sub, carry, AND, greater/lesser/equal) and the op select, and picks the one result the
//   op asks for. It derives a flag word from that result.
// - The selected result and flags go into a DEPTH-entry FIFO. The consumer drains it through a
//   valid/ready handshake.
// - A sticky error flag catches ALU compare outputs that are not one-hot.
// PARAMETERS
// - W      4  data width; equals the ALU operand width
// - DEPTH  2  FIFO entries; must be a power of 2, >= 2
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous active-low reset
// - in_valid    in   1      ALU outputs and op are valid this cycle
// - in_ready    out  1      stage can accept (FIFO not full)
// - op          in   2      {S1,S0}: 00 ADD, 01 SUB, 10 AND, 11 CMP
// - alu_sum     in   W      ALU adder/subtractor output
// - alu_carry   in   1      ALU carry/borrow-out
// - alu_and     in   W      ALU bitwise AND output
// - alu_gt      in   1      A>B
// - alu_lt      in   1      A<B
// - alu_eq      in   1      A==B
// - out_valid   out  1      head FIFO entry is valid
// - out_ready   in   1      consumer accepts the head entry
// - out_result  out  W      head entry result
// - out_flags   out  4      head entry flags {LT,GT,C,Z} (bits 3..0)
// - cmp_err     out  1      sticky: an accepted CMP had non-one-hot {gt,lt,eq}
// - err_clr     in   1      synchronous clear of cmp_err
// BEHAVIOUR
// - Reset (rst_n low, asynchronous): every output except in_ready goes to 0 immediately.
//   in_ready goes to 1. Pointers and count clear. Storage contents are don't-care but out_*
//   read 0 while the FIFO is empty.
// - Accept: push when in_valid && in_ready. Pop when out_valid && out_ready. Both act on the
//   rising edge.
// - Selection:
//   - ADD/SUB: result = alu_sum; C = alu_carry; GT = LT = 0; Z = (alu_sum == 0).
//   - AND: result = alu_and; C = GT = LT = 0; Z = (alu_and == 0).
//   - CMP: result = {{W-3{1'b0}}, alu_gt, alu_eq, alu_lt}; C = 0; GT = alu_gt; LT = alu_lt;
//     Z = alu_eq.
// - Latency: a word pushed at edge N shows on out_* with out_valid=1 after edge N (one cycle).
//   This holds even when the FIFO was empty; there is no combinational bypass.
// - in_ready = (count != DEPTH). It is a function of registered state only; out_ready does not
//   feed it.
// - Full with a pop in the same cycle: the pop happens and no push happens (in_ready was 0).
//   in_ready returns to 1 on the next cycle.
// - Push and pop in the same cycle at 0 < count < DEPTH: count is unchanged and both pointers
//   advance.
// - Empty: out_valid = 0, and out_ready is ignored.
// - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits,
//   range 0..DEPTH.
// - out_* stay stable while out_valid && !out_ready.
// - cmp_err: set on an accepted CMP where alu_gt + alu_lt + alu_eq != 1. Cleared by err_clr.
//   If set and clear happen in the same cycle, set wins. The erroneous word is still pushed
//   unchanged.
// - Reset mid-operation: all queued entries are discarded. No partial pop is visible.
// - Invariant: op and the ALU inputs are sampled only on an accepted push. Values while
//   in_valid = 0 have no effect.
// STRUCTURE
// - Shared include alu_defs.vh holds:
//   - op localparams OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_CMP = 2'b11;
//   - flag bit indices FLG_Z = 0, FLG_C = 1, FLG_GT = 2, FLG_LT = 3.
//   The ALU and its bench use the same file.
// - One sub-module, alu_sync_fifo (params W_DATA = W+4, DEPTH). It contains the FIFO storage,
//   pointers, count, and full/empty logic.
// - The result select, flag derivation and cmp_err register live in the top module.
// TESTING
// - ADD, A=1101 B=1001: alu_sum=0110, carry=1 -> out_result=0110, out_flags=0010 one cycle
//   after the push.
// - CMP, A=1000 B=1000 (eq=1) -> result=0010, flags=0001. Then CMP with gt=1 -> result=0100,
//   flags=0100. cmp_err stays 0.
// - AND, A=0011 B=1100: and=0000 -> result=0000, flags=0001 (Z set).
// - Hold out_ready=0 and push 3 words: in_ready drops after 2 and the 3rd stalls. Assert
//   out_ready: words pop in order, and in_ready=1 the cycle after the first pop.
// - CMP with gt=lt=1 -> cmp_err=1 and stays 1. err_clr pulse -> 0. err_clr coincident with a
//   new bad CMP -> stays 1.
// - Assert rst_n low mid-drain with 2 entries queued: out_valid=0 and in_ready=1 immediately
//   (asynchronously). No stale data appears after release.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: op encodings, flag bit positions
// and the compare-output sanity helper.
package alu_result_stage_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_CMP = 2'b11
    } alu_op_e;

    localparam int FLG_Z   = 0;
    localparam int FLG_C   = 1;
    localparam int FLG_GT  = 2;
    localparam int FLG_LT  = 3;
    localparam int FLAGS_W = 4;

    // True when exactly one of the three compare outputs is asserted.
    function automatic logic cmp_onehot(input logic gt, input logic lt, input logic eq);
        logic [1:0] n;
        n = {1'b0, gt} + {1'b0, lt} + {1'b0, eq};
        return (n == 2'd1);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Producer/consumer bus of the ALU result stage: ALU outputs in, FIFO head out.
interface alu_result_stage_if #(
    parameter int W = 4
);
    import alu_result_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [W-1:0]       alu_sum;
    logic               alu_carry;
    logic [W-1:0]       alu_and;
    logic               alu_gt;
    logic               alu_lt;
    logic               alu_eq;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_result;
    logic [FLAGS_W-1:0] out_flags;

    modport master (
        output in_valid, op, alu_sum, alu_carry, alu_and, alu_gt, alu_lt, alu_eq, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, op, alu_sum, alu_carry, alu_and, alu_gt, alu_lt, alu_eq, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; the read port shows zero while empty
// so nothing stale leaks out after reset or a full drain.
module alu_sync_fifo #(
    parameter int W_DATA = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [W_DATA-1:0] wdata,
    output logic [W_DATA-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W_DATA-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap at the natural power-of-two boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset because empty masks the read port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head-of-queue read, forced to zero while empty.
    always_comb begin
        rdata = {W_DATA{1'b0}};
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = {W_DATA{1'b0}};
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage behind the 4-bit ALU: selects the result for the op, derives
// {LT,GT,C,Z} flags, queues them for a valid/ready consumer and tracks bad compares.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    input  logic                err_clr,
    output logic                cmp_err
);

    localparam int WD = W + FLAGS_W;

    logic [W-1:0]       result_s;
    logic [FLAGS_W-1:0] flags_s;
    logic [WD-1:0]      head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic               bad_cmp_s;
    logic               cmp_err_r;

    assign push_s = bus.in_valid && !fifo_full_s;
    assign pop_s  = !fifo_empty_s && bus.out_ready;

    // Pick the one ALU output the op asks for and derive its flag word.
    always_comb begin
        result_s  = {W{1'b0}};
        flags_s   = {FLAGS_W{1'b0}};
        bad_cmp_s = 1'b0;
        case (alu_op_e'(bus.op))
            OP_ADD, OP_SUB: begin
                result_s        = bus.alu_sum;
                flags_s[FLG_C]  = bus.alu_carry;
                flags_s[FLG_Z]  = (bus.alu_sum == {W{1'b0}});
            end
            OP_AND: begin
                result_s        = bus.alu_and;
                flags_s[FLG_Z]  = (bus.alu_and == {W{1'b0}});
            end
            OP_CMP: begin
                // Compare outputs are passed through untouched, even when not one-hot.
                result_s        = {{(W-3){1'b0}}, bus.alu_gt, bus.alu_eq, bus.alu_lt};
                flags_s[FLG_GT] = bus.alu_gt;
                flags_s[FLG_LT] = bus.alu_lt;
                flags_s[FLG_Z]  = bus.alu_eq;
                bad_cmp_s       = !cmp_onehot(bus.alu_gt, bus.alu_lt, bus.alu_eq);
            end
            default: begin
                result_s  = {W{1'b0}};
                flags_s   = {FLAGS_W{1'b0}};
                bad_cmp_s = 1'b0;
            end
        endcase
    end

    alu_sync_fifo #(
        .W_DATA (WD),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({result_s, flags_s}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sticky compare-error flag; a new error outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_err_r <= 1'b0;
        end else if (push_s && bad_cmp_s) begin
            cmp_err_r <= 1'b1;
        end else if (err_clr) begin
            cmp_err_r <= 1'b0;
        end else begin
            cmp_err_r <= cmp_err_r;
        end
    end

    assign cmp_err        = cmp_err_r;
    assign bus.in_ready   = !fifo_full_s;
    assign bus.out_valid  = !fifo_empty_s;
    assign bus.out_result = head_s[WD-1:FLAGS_W];
    assign bus.out_flags  = head_s[FLAGS_W-1:0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_alu_result_stage;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic err_clr = 1'b0;
    logic cmp_err;

    int errors = 0;
    int checks = 0;

    alu_result_stage_if #(.W(W)) bus ();

    alu_result_stage #(.W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .err_clr (err_clr),
        .cmp_err (cmp_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.alu_sum   = 4'h0;
        bus.alu_carry = 1'b0;
        bus.alu_and   = 4'h0;
        bus.alu_gt    = 1'b0;
        bus.alu_lt    = 1'b0;
        bus.alu_eq    = 1'b0;
    endtask

    // Behave like the upstream 4-bit ALU for operands a, b.
    task automatic drive_alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = (op == 2'b01) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        bus.op        = op;
        bus.alu_sum   = s[3:0];
        bus.alu_carry = s[4];
        bus.alu_and   = a & b;
        bus.alu_gt    = (a > b);
        bus.alu_lt    = (a < b);
        bus.alu_eq    = (a == b);
    endtask

    // Reference: {result, flags{LT,GT,C,Z}} from the selection rules.
    function automatic logic [7:0] exp_word(input logic [1:0] op, input logic [3:0] sum,
                                            input logic carry, input logic [3:0] andv,
                                            input logic gt, input logic lt, input logic eq);
        int r;
        case (op)
            2'd0, 2'd1: return {sum, 1'b0, 1'b0, carry, sum == 4'd0};
            2'd2:       return {andv, 3'b000, andv == 4'd0};
            default: begin
                r = 4 * int'(gt) + 2 * int'(eq) + int'(lt);
                return {4'(r), lt, gt, 1'b0, eq};
            end
        endcase
    endfunction

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.out_result, bus.out_flags} !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", {bus.out_result, bus.out_flags}); end
        checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL reset_cmp_err got=%b exp=0", cmp_err); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        drive_alu(2'b00, 4'b1101, 4'b1001);
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_no_bypass got=%b exp=0", bus.out_valid); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_result !== 4'b0110) begin errors++; $display("FAIL add_result got=%b exp=0110", bus.out_result); end
        checks++; if (bus.out_flags !== 4'b0010) begin errors++; $display("FAIL add_flags got=%b exp=0010", bus.out_flags); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_cmp();
        drive_alu(2'b11, 4'b1000, 4'b1000);
        bus.in_valid = 1'b1;
        step();
        checks++; if ({bus.out_result, bus.out_flags} !== 8'b0010_0001) begin errors++; $display("FAIL cmp_eq got=%b exp=00100001", {bus.out_result, bus.out_flags}); end
        drive_alu(2'b11, 4'b1001, 4'b1000);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cmp_pushpop_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.out_result, bus.out_flags} !== 8'b0100_0100) begin errors++; $display("FAIL cmp_gt got=%b exp=01000100", {bus.out_result, bus.out_flags}); end
        step();
        bus.out_ready = 1'b0;
        checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL cmp_err_clean got=%b exp=0", cmp_err); end
    endtask

    task automatic test_and();
        drive_alu(2'b10, 4'b0011, 4'b1100);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        checks++; if ({bus.out_result, bus.out_flags} !== 8'b0000_0001) begin errors++; $display("FAIL and_zero got=%b exp=00000001", {bus.out_result, bus.out_flags}); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] want;
        for (int i = 0; i < 3; i++) begin
            drive_alu(2'b00, 4'(i + 1), 4'd1);
            bus.in_valid = 1'b1;
            checks++; if (bus.in_ready !== (i < 2)) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, i < 2); end
            step();
        end
        checks++; if (bus.out_result !== 4'd2) begin errors++; $display("FAIL bp_head0 got=%0d exp=2", bus.out_result); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_result !== 4'd3) begin errors++; $display("FAIL bp_head1 got=%0d exp=3", bus.out_result); end
        step();
        bus.in_valid = 1'b0;
        want = 4'd4;
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, want, 4'b0000}) begin errors++; $display("FAIL bp_head2 got=%b_%b exp=4", bus.out_valid, bus.out_result); end
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_cmp_err();
        drive_alu(2'b11, 4'd5, 4'd3);
        bus.alu_lt = 1'b1;
        step();
        checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL err_needs_valid got=%b exp=0", cmp_err); end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", cmp_err); end
        checks++; if ({bus.out_result, bus.out_flags} !== 8'b0101_1100) begin errors++; $display("FAIL err_word got=%b exp=01011100", {bus.out_result, bus.out_flags}); end
        bus.out_ready = 1'b1;
        step();
        step();
        bus.out_ready = 1'b0;
        checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", cmp_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", cmp_err); end
        err_clr      = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        err_clr      = 1'b0;
        checks++; if (cmp_err !== 1'b1) begin errors++; $display("FAIL err_set_wins got=%b exp=1", cmp_err); end
        bus.out_ready = 1'b1;
        err_clr       = 1'b1;
        step();
        bus.out_ready = 1'b0;
        err_clr       = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 2; i++) begin
            drive_alu(2'b10, 4'hF, 4'(i + 6));
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.out_result, bus.out_flags} !== 8'h00) begin errors++; $display("FAIL rst_async_data got=%h exp=00", {bus.out_result, bus.out_flags}); end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== 9'h000) begin errors++; $display("FAIL rst_no_stale got=%h exp=000", {bus.out_valid, bus.out_result, bus.out_flags}); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] exp_head;
        logic       exp_err;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       push;
        logic       pop;
        exp_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_head = (q.size() > 0) ? q[0] : 8'h00;
            checks++; if (bus.in_ready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, q.size() != DEPTH); end
            checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, q.size() != 0); end
            checks++; if ({bus.out_result, bus.out_flags} !== exp_head) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, {bus.out_result, bus.out_flags}, exp_head); end
            checks++; if (cmp_err !== exp_err) begin errors++; $display("FAIL rnd_cmp_err cyc=%0d got=%b exp=%b", cyc, cmp_err, exp_err); end
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            drive_alu(op, a, b);
            if ($urandom_range(0, 3) == 0) begin
                bus.alu_gt = 1'($urandom_range(0, 1));
                bus.alu_lt = 1'($urandom_range(0, 1));
                bus.alu_eq = 1'($urandom_range(0, 1));
            end
            bus.in_valid  = 1'($urandom_range(0, 2) != 0);
            bus.out_ready = 1'($urandom_range(0, 2) != 0);
            err_clr       = ($urandom_range(0, 7) == 0);
            push = bus.in_valid && (q.size() < DEPTH);
            pop  = bus.out_ready && (q.size() > 0);
            if (push && op == 2'b11 &&
                (int'(bus.alu_gt) + int'(bus.alu_lt) + int'(bus.alu_eq) != 1)) begin
                exp_err = 1'b1;
            end else if (err_clr) begin
                exp_err = 1'b0;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back(exp_word(op, bus.alu_sum, bus.alu_carry, bus.alu_and,
                                           bus.alu_gt, bus.alu_lt, bus.alu_eq));
            step();
        end
        idle();
        err_clr = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_add();
        test_cmp();
        test_and();
        test_back_to_back();
        test_cmp_err();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
